redun_port_sel: RTL and testbench
=================================

// Module: redun_port_sel
// PURPOSE
//  N-channel generalisation of the dual-redundancy downstream-to-upstream mux.
//  Selects one of N_CH GMII-style byte streams, all in the clk domain after
//  their pkt_fifo, and forwards it to the upstream tx path.
//  Switches only on frame boundaries and supports manual (MCU GPIO) or automatic
//  link-driven failover, with a holdoff so link flaps cannot thrash the choice.
// PARAMETERS
//  N_CH            2       number of redundant channels (2..8)
//  DATA_W          8       data byte width per channel
//  HOLDOFF_CYCLES  125000  min cycles between two switches (1 ms @125 MHz); 0 = none
//  SEL_W           derived localparam = max(1,$clog2(N_CH))
// PORTS
//  clk          in   1             single clock, all logic rising-edge
//  rst          in   1             synchronous reset, active-high
//  link         in   N_CH          per-channel link-up status (from GPIO)
//  auto_en      in   1             1 = automatic failover, 0 = manual
//  manual_sel   in   SEL_W         requested channel when auto_en=0
//  rx_data      in   N_CH*DATA_W   channel k at [k*DATA_W +: DATA_W]
//  rx_dv        in   N_CH          per-channel data valid
//  rx_er        in   N_CH          per-channel error
//  tx_data      out  DATA_W        selected stream, registered
//  tx_en        out  1             selected dv, registered
//  tx_er        out  1             selected er, registered (or forced, see below)
//  sel          out  SEL_W         currently forwarded channel
//  switch_pulse out  1             1-cycle strobe in the cycle sel changes
// BEHAVIOUR
//  Reset: tx_data=0, tx_en=0, tx_er=0, sel=0, switch_pulse=0, holdoff cnt=0, state FWD.
//  Latency: 1 cycle; tx_*(t+1) = rx_*[sel](t) while forwarding.
//  Target: auto_en=0 -> manual_sel (values >= N_CH ignored, target=sel).
//   auto_en=1 -> keep sel if link[sel]=1; else first k with link[k]=1, searching
//   sel+1, sel+2, ... mod N_CH; if no link is up, target=sel.
//  States:
//   FWD: forward sel; if target!=sel and holdoff cnt==0 -> PEND.
//   PEND: keep forwarding sel; in a cycle where rx_dv[sel]=0 and
//     rx_dv[target]=0 -> sel<=target, switch_pulse=1, cnt<=HOLDOFF_CYCLES, -> FWD.
//     If target returns to sel while pending -> FWD, no switch.
//  The output never begins mid-frame. A channel that goes active while another is
//   selected is dropped until its own dv falls.
//  Mid-frame loss: link[sel] 1->0 while rx_dv[sel]=1 -> next cycle tx_en=1,
//   tx_er=1, data=0 for one cycle, then tx_en=0 (frame poisoned). Ignore rx_dv[sel]
//   until it falls.
//  Holdoff: cnt decrements to 0 each cycle; target changes are re-evaluated only at 0.
//  Simultaneous: link loss and target change in one cycle -> poison first, then switch.
//  rst mid-frame: outputs go to reset values next cycle (truncated frame).
// CONFIGURATION
//  REDUN_SEL_STATS_EN defined: adds output failover_cnt [15:0]. It counts sel
//   changes made with auto_en=1, saturates at 16'hFFFF and clears on rst.
//   Also adds output poison_cnt [15:0] with the same rules for mid-frame poison events.
//  Undefined: neither port nor counter exists; behaviour otherwise identical.
// TESTING
//  N_CH=2, auto, link=2'b11, 64-byte frame on ch0 -> tx mirrors it, 1-cycle delay, sel=0.
//  Drop link[0] mid-frame on byte 20 -> byte 21 slot: tx_en=1, tx_er=1; then sel=1 at ch1 idle.
//  Manual sel 0->1 while ch0 mid-frame -> ch0 frame completes intact, then switch_pulse, sel=1.
//  N_CH=4, auto, link 4'b1001 with sel=0, drop link[0] -> sel=3; restore link[0] -> sel stays 3.
//  HOLDOFF_CYCLES=100, link flaps every 10 cycles -> switch_pulse spacing >= 100.
//  With REDUN_SEL_STATS_EN: 3 auto failovers -> failover_cnt=3; rst -> 0.

Source files
------------

// File: rtl/redun_port_sel.sv
// redun_port_sel
//
// Purpose:
//   N-channel redundant downstream-to-upstream byte-stream selector. It picks
//   one of N_CH GMII-style streams and forwards it, registered, to the
//   upstream tx path. A switch happens only on a frame boundary. Failover is
//   either manual (MCU GPIO) or automatic (link driven). A holdoff stops link
//   flaps from thrashing the choice of channel.
//
// Parameters:
//   N_CH            number of redundant channels (2..8)
//   DATA_W          data width per channel
//   HOLDOFF_CYCLES  minimum number of cycles between two switches (0 = none)
//   SEL_W           channel index width, derived from N_CH (keep the default)
//
// Ports:
//   clk           single rising-edge clock
//   rst           synchronous reset, active-high
//   link          per-channel link-up status
//   auto_en       1 = automatic failover, 0 = manual selection
//   manual_sel    requested channel in manual mode (values >= N_CH are ignored)
//   rx_data       channel k sits at [k*DATA_W +: DATA_W]
//   rx_dv, rx_er  per-channel data valid / error
//   tx_data       selected data, registered
//   tx_en         selected data valid, registered
//   tx_er         selected error, registered (forced high on a poisoned frame)
//   sel           channel currently forwarded
//   switch_pulse  one-cycle strobe in the first cycle that sel holds a new value
//
// Optional feature, macro REDUN_SEL_STATS_EN:
//   Adds the outputs failover_cnt[15:0] and poison_cnt[15:0].
//   failover_cnt counts channel switches made in automatic mode.
//   poison_cnt counts frames poisoned by a mid-frame link loss.
//   Both saturate at 16'hFFFF and clear on rst.
module redun_port_sel #(
  parameter int N_CH           = 2,
  parameter int DATA_W         = 8,
  parameter int HOLDOFF_CYCLES = 125000,
  parameter int SEL_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        link,
  input  logic                   auto_en,
  input  logic [SEL_W-1:0]       manual_sel,
  input  logic [N_CH*DATA_W-1:0] rx_data,
  input  logic [N_CH-1:0]        rx_dv,
  input  logic [N_CH-1:0]        rx_er,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   tx_en,
  output logic                   tx_er,
  output logic [SEL_W-1:0]       sel,
  output logic                   switch_pulse
`ifdef REDUN_SEL_STATS_EN
  ,
  output logic [15:0]            failover_cnt,
  output logic [15:0]            poison_cnt
`endif
);

  localparam int CNT_W = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES);

  typedef enum logic {FWD, PEND} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  hold_cnt;
  logic [N_CH-1:0]   link_prev;
  logic              squelch;
  logic [SEL_W-1:0]  target;
  logic [SEL_W-1:0]  cand;
  logic              found;
  logic [DATA_W-1:0] cur_data;
  logic              cur_dv;
  logic              cur_er;
  logic              poison_now;
  logic              do_switch;

  // Byte lane of the currently selected channel.
  always_comb begin
    cur_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel == SEL_W'(k)) cur_data = rx_data[k*DATA_W +: DATA_W];
    end
  end

  assign cur_dv = rx_dv[sel];
  assign cur_er = rx_er[sel];

  // A link that drops while the selected channel is inside a frame poisons
  // that frame once. The rest of the frame is then squelched.
  assign poison_now = cur_dv & link_prev[sel] & ~link[sel] & ~squelch;

  // Channel we would like to forward. In automatic mode the current channel
  // is kept while its link is up. Otherwise the search runs round-robin,
  // starting after sel. If no link is up, the choice stays where it is.
  always_comb begin
    target = sel;
    found  = 1'b0;
    cand   = '0;
    if (!auto_en) begin
      if (int'(manual_sel) < N_CH) target = manual_sel;
    end else if (!link[sel]) begin
      for (int i = 1; i < N_CH; i++) begin
        cand = SEL_W'((int'(sel) + i) % N_CH);
        if (!found && link[cand]) begin
          target = cand;
          found  = 1'b1;
        end
      end
    end
  end

  // Switch decision. A pending switch waits until both the old channel and
  // the new channel are idle in the same cycle. This means the output never
  // begins mid-frame, and a frame already running on the new channel is
  // dropped.
  always_comb begin
    state_d   = state_q;
    do_switch = 1'b0;
    case (state_q)
      FWD: begin
        if (target != sel && hold_cnt == '0) state_d = PEND;
      end
      PEND: begin
        if (target == sel) begin
          state_d = FWD;
        end else if (!cur_dv && !rx_dv[target]) begin
          do_switch = 1'b1;
          state_d   = FWD;
        end
      end
      default: state_d = FWD;
    endcase
  end

  // Selection state, switch strobe and holdoff counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FWD;
      sel          <= '0;
      switch_pulse <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      state_q      <= state_d;
      switch_pulse <= do_switch;
      if (do_switch) begin
        sel      <= target;
        hold_cnt <= HOLDOFF_LOAD;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - CNT_W'(1);
      end
    end
  end

  // Registered tx path. A poisoned slot carries en=1, er=1 and zero data.
  // The slots after it stay idle until the selected dv falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data   <= '0;
      tx_en     <= 1'b0;
      tx_er     <= 1'b0;
      squelch   <= 1'b0;
      link_prev <= '0;
    end else begin
      link_prev <= link;
      if (poison_now) begin
        tx_data <= '0;
        tx_en   <= 1'b1;
        tx_er   <= 1'b1;
        squelch <= 1'b1;
      end else if (squelch) begin
        tx_data <= '0;
        tx_en   <= 1'b0;
        tx_er   <= 1'b0;
        if (!cur_dv) squelch <= 1'b0;
      end else begin
        tx_data <= cur_data;
        tx_en   <= cur_dv;
        tx_er   <= cur_er;
      end
    end
  end

`ifdef REDUN_SEL_STATS_EN
  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      failover_cnt <= '0;
      poison_cnt   <= '0;
    end else begin
      if (do_switch && auto_en && failover_cnt != 16'hFFFF)
        failover_cnt <= failover_cnt + 16'd1;
      if (poison_now && poison_cnt != 16'hFFFF)
        poison_cnt <= poison_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_redun_port_sel.sv
// tb_redun_port_sel
//
// Directed bench for redun_port_sel. Two instances are used:
//   u_dut2  N_CH=2, no holdoff: forwarding, poisoning, manual switching, reset
//   u_dut4  N_CH=4, HOLDOFF_CYCLES=100: link failover order and holdoff spacing
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge, half a cycle after the rising edge that registered them.
// With REDUN_SEL_STATS_EN defined, the statistics counters are checked too.
module tb_redun_port_sel;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  logic [1:0]  link2;
  logic        auto2;
  logic [0:0]  msel2;
  logic [15:0] rxd2;
  logic [1:0]  dv2;
  logic [1:0]  er2;
  logic [7:0]  txd2;
  logic        txen2;
  logic        txer2;
  logic [0:0]  sel2;
  logic        sp2;

  logic [3:0]  link4;
  logic        auto4;
  logic [1:0]  msel4;
  logic [31:0] rxd4;
  logic [3:0]  dv4;
  logic [3:0]  er4;
  logic [7:0]  txd4;
  logic        txen4;
  logic        txer4;
  logic [1:0]  sel4;
  logic        sp4;

`ifdef REDUN_SEL_STATS_EN
  logic [15:0] fc2, pc2, fc4, pc4;
`endif

  int checks = 0;
  int passed = 0;

  redun_port_sel #(.N_CH(2), .DATA_W(8), .HOLDOFF_CYCLES(0)) u_dut2 (
    .clk          (clk),
    .rst          (rst),
    .link         (link2),
    .auto_en      (auto2),
    .manual_sel   (msel2),
    .rx_data      (rxd2),
    .rx_dv        (dv2),
    .rx_er        (er2),
    .tx_data      (txd2),
    .tx_en        (txen2),
    .tx_er        (txer2),
    .sel          (sel2),
    .switch_pulse (sp2)
`ifdef REDUN_SEL_STATS_EN
    , .failover_cnt (fc2), .poison_cnt (pc2)
`endif
  );

  redun_port_sel #(.N_CH(4), .DATA_W(8), .HOLDOFF_CYCLES(100)) u_dut4 (
    .clk          (clk),
    .rst          (rst),
    .link         (link4),
    .auto_en      (auto4),
    .manual_sel   (msel4),
    .rx_data      (rxd4),
    .rx_dv        (dv4),
    .rx_er        (er4),
    .tx_data      (txd4),
    .tx_en        (txen4),
    .tx_er        (txer4),
    .sel          (sel4),
    .switch_pulse (sp4)
`ifdef REDUN_SEL_STATS_EN
    , .failover_cnt (fc4), .poison_cnt (pc4)
`endif
  );

  // Reset with busy inputs: every output must sit at its reset value.
  task automatic test_reset();
    rst = 1'b1;
    link2 = 2'b11; auto2 = 1'b1; msel2 = 1'b0; rxd2 = 16'h5A5A; dv2 = 2'b11; er2 = 2'b11;
    link4 = 4'b1001; auto4 = 1'b1; msel4 = 2'd0; rxd4 = 32'hA5A5A5A5; dv4 = 4'hF; er4 = 4'hF;
    repeat (3) @(negedge clk);
    checks++;
    if (txen2 !== 1'b0 || txer2 !== 1'b0 || txd2 !== 8'h00)
      $display("[TB] FAIL reset_tx2: got en=%b er=%b data=%h, want 0 0 00", txen2, txer2, txd2);
    else passed++;
    checks++;
    if (sel2 !== 1'b0 || sp2 !== 1'b0)
      $display("[TB] FAIL reset_sel2: got sel=%0d pulse=%b, want 0 0", sel2, sp2);
    else passed++;
    checks++;
    if (txen4 !== 1'b0 || txer4 !== 1'b0 || txd4 !== 8'h00 || sel4 !== 2'd0 || sp4 !== 1'b0)
      $display("[TB] FAIL reset_dut4: got en=%b er=%b data=%h sel=%0d pulse=%b, want all 0",
               txen4, txer4, txd4, sel4, sp4);
    else passed++;
`ifdef REDUN_SEL_STATS_EN
    checks++;
    if (fc2 !== 16'd0 || pc2 !== 16'd0)
      $display("[TB] FAIL reset_stats: got failover=%0d poison=%0d, want 0 0", fc2, pc2);
    else passed++;
`endif
    rst = 1'b0;
    rxd2 = '0; dv2 = '0; er2 = '0;
    rxd4 = '0; dv4 = '0; er4 = '0;
    @(negedge clk);
    checks++;
    if (txen2 !== 1'b0 || sel2 !== 1'b0)
      $display("[TB] FAIL post_reset_idle: got en=%b sel=%0d, want 0 0", txen2, sel2);
    else passed++;
  endtask

  // 64-byte frame on ch0 with both links up: a one-cycle-delayed copy.
  task automatic test_forward();
    logic [7:0] expd;
    for (int i = 0; i <= 64; i++) begin
      expd = 8'(i * 3 + 1);
      rxd2[15:8] = 8'hEE;
      if (i < 64) begin
        rxd2[7:0] = expd;
        dv2[0] = 1'b1;
        er2[0] = (i == 30);
      end else begin
        rxd2[7:0] = 8'h00;
        dv2[0] = 1'b0;
        er2[0] = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (i < 64) begin
        if (txen2 !== 1'b1 || txd2 !== expd || txer2 !== (i == 30) || sel2 !== 1'b0)
          $display("[TB] FAIL fwd_byte%0d: got en=%b er=%b data=%h sel=%0d, want 1 %b %h 0",
                   i, txen2, txer2, txd2, sel2, (i == 30), expd);
        else passed++;
      end else begin
        if (txen2 !== 1'b0 || txer2 !== 1'b0)
          $display("[TB] FAIL fwd_end: got en=%b er=%b, want 0 0", txen2, txer2);
        else passed++;
      end
    end
  endtask

  // link[0] drops on byte index 20: that slot is poisoned and the rest of
  // the frame is squelched. The switch to ch1 happens once ch0 goes idle.
  task automatic test_midframe_loss();
    for (int i = 0; i <= 40; i++) begin
      rxd2[7:0] = (i < 40) ? 8'(8'h80 + i) : 8'h00;
      dv2[0] = (i < 40);
      if (i == 20) link2 = 2'b10;
      @(negedge clk);
      checks++;
      if (i < 20) begin
        if (txen2 !== 1'b1 || txer2 !== 1'b0 || txd2 !== 8'(8'h80 + i) || sel2 !== 1'b0)
          $display("[TB] FAIL loss_pre%0d: got en=%b er=%b data=%h sel=%0d, want 1 0 %h 0",
                   i, txen2, txer2, txd2, sel2, 8'(8'h80 + i));
        else passed++;
      end else if (i == 20) begin
        if (txen2 !== 1'b1 || txer2 !== 1'b1 || txd2 !== 8'h00 || sel2 !== 1'b0)
          $display("[TB] FAIL loss_poison: got en=%b er=%b data=%h sel=%0d, want 1 1 00 0",
                   txen2, txer2, txd2, sel2);
        else passed++;
      end else if (i < 40) begin
        if (txen2 !== 1'b0 || txer2 !== 1'b0 || sel2 !== 1'b0 || sp2 !== 1'b0)
          $display("[TB] FAIL loss_squelch%0d: got en=%b er=%b sel=%0d pulse=%b, want 0 0 0 0",
                   i, txen2, txer2, sel2, sp2);
        else passed++;
      end else begin
        if (sel2 !== 1'b1 || sp2 !== 1'b1 || txen2 !== 1'b0)
          $display("[TB] FAIL loss_switch: got sel=%0d pulse=%b en=%b, want 1 1 0", sel2, sp2, txen2);
        else passed++;
      end
    end
    @(negedge clk);
    checks++;
    if (sp2 !== 1'b0 || sel2 !== 1'b1)
      $display("[TB] FAIL loss_pulse_width: got pulse=%b sel=%0d, want 0 1", sp2, sel2);
    else passed++;
    // ch1 is now forwarded
    for (int i = 0; i <= 4; i++) begin
      rxd2[15:8] = 8'(8'hC0 + i);
      dv2[1] = (i < 4);
      @(negedge clk);
      checks++;
      if (txen2 !== (i < 4) || (i < 4 && txd2 !== 8'(8'hC0 + i)))
        $display("[TB] FAIL ch1_fwd%0d: got en=%b data=%h, want %b %h", i, txen2, txd2, (i < 4), 8'(8'hC0 + i));
      else passed++;
    end
`ifdef REDUN_SEL_STATS_EN
    checks++;
    if (fc2 !== 16'd1 || pc2 !== 16'd1)
      $display("[TB] FAIL loss_stats: got failover=%0d poison=%0d, want 1 1", fc2, pc2);
    else passed++;
`endif
  endtask

  // Manual 1->0 on an idle line, then manual 0->1 while ch0 is mid-frame:
  // the frame finishes intact before the switch.
  task automatic test_manual();
    link2 = 2'b11; auto2 = 1'b0; msel2 = 1'b1; rxd2 = '0; dv2 = '0;
    @(negedge clk);
    msel2 = 1'b0;
    @(negedge clk);
    checks++;
    if (sel2 !== 1'b1 || sp2 !== 1'b0)
      $display("[TB] FAIL man_pend: got sel=%0d pulse=%b, want 1 0", sel2, sp2);
    else passed++;
    @(negedge clk);
    checks++;
    if (sel2 !== 1'b0 || sp2 !== 1'b1)
      $display("[TB] FAIL man_to0: got sel=%0d pulse=%b, want 0 1", sel2, sp2);
    else passed++;
    for (int i = 0; i <= 16; i++) begin
      rxd2[7:0] = 8'(8'h40 + i);
      dv2[0] = (i < 16);
      if (i == 5) msel2 = 1'b1;
      @(negedge clk);
      checks++;
      if (i < 16) begin
        if (txen2 !== 1'b1 || txd2 !== 8'(8'h40 + i) || sel2 !== 1'b0 || sp2 !== 1'b0)
          $display("[TB] FAIL man_frame%0d: got en=%b data=%h sel=%0d pulse=%b, want 1 %h 0 0",
                   i, txen2, txd2, sel2, sp2, 8'(8'h40 + i));
        else passed++;
      end else begin
        if (sel2 !== 1'b1 || sp2 !== 1'b1 || txen2 !== 1'b0)
          $display("[TB] FAIL man_to1: got sel=%0d pulse=%b en=%b, want 1 1 0", sel2, sp2, txen2);
        else passed++;
      end
    end
`ifdef REDUN_SEL_STATS_EN
    checks++;
    if (fc2 !== 16'd1)
      $display("[TB] FAIL man_not_counted: got failover=%0d, want 1", fc2);
    else passed++;
`endif
  endtask

  // Switching to a channel that is already mid-frame waits until that frame
  // ends; the frame is not forwarded. Back-to-back frames on the new channel
  // are then forwarded whole.
  task automatic test_back_to_back();
    logic expdv;
    rxd2 = '0; dv2 = '0;
    for (int i = 0; i <= 8; i++) begin
      rxd2[7:0] = 8'(8'h20 + i);
      dv2[0] = (i < 8);
      if (i == 0) msel2 = 1'b0;
      @(negedge clk);
      checks++;
      if (i < 8) begin
        if (txen2 !== 1'b0 || sel2 !== 1'b1)
          $display("[TB] FAIL b2b_drop%0d: got en=%b sel=%0d, want 0 1", i, txen2, sel2);
        else passed++;
      end else begin
        if (sel2 !== 1'b0 || sp2 !== 1'b1)
          $display("[TB] FAIL b2b_switch: got sel=%0d pulse=%b, want 0 1", sel2, sp2);
        else passed++;
      end
    end
    for (int j = 0; j < 8; j++) begin
      expdv = (j != 3 && j != 7);
      rxd2[7:0] = 8'(8'h60 + j);
      dv2[0] = expdv;
      @(negedge clk);
      checks++;
      if (txen2 !== expdv || (expdv && txd2 !== 8'(8'h60 + j)) || sel2 !== 1'b0)
        $display("[TB] FAIL b2b_frame%0d: got en=%b data=%h sel=%0d, want %b %h 0",
                 j, txen2, txd2, sel2, expdv, 8'(8'h60 + j));
      else passed++;
    end
    dv2 = '0;
  endtask

  // Reset while a ch1 frame is being forwarded: truncated on the next cycle.
  task automatic test_reset_midframe();
    msel2 = 1'b1; dv2 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (sel2 !== 1'b1)
      $display("[TB] FAIL rstm_presel: got sel=%0d, want 1", sel2);
    else passed++;
    for (int i = 0; i <= 4; i++) begin
      rxd2[15:8] = 8'(8'h90 + i);
      dv2[1] = 1'b1;
      if (i == 4) rst = 1'b1;
      @(negedge clk);
      checks++;
      if (i < 4) begin
        if (txen2 !== 1'b1 || txd2 !== 8'(8'h90 + i))
          $display("[TB] FAIL rstm_fwd%0d: got en=%b data=%h, want 1 %h", i, txen2, txd2, 8'(8'h90 + i));
        else passed++;
      end else begin
        if (txen2 !== 1'b0 || txer2 !== 1'b0 || txd2 !== 8'h00 || sel2 !== 1'b0 || sp2 !== 1'b0)
          $display("[TB] FAIL rstm_cut: got en=%b er=%b data=%h sel=%0d pulse=%b, want all 0",
                   txen2, txer2, txd2, sel2, sp2);
        else passed++;
      end
    end
    rst = 1'b0; dv2 = '0; msel2 = 1'b0;
    @(negedge clk);
    checks++;
    if (sel2 !== 1'b0 || txen2 !== 1'b0)
      $display("[TB] FAIL rstm_after: got sel=%0d en=%b, want 0 0", sel2, txen2);
    else passed++;
  endtask

  // 4 channels: failover order is round-robin after sel; a link that
  // comes back does not pull the selection back.
  task automatic test_failover();
    int n_sp;
    link4 = 4'b1000;
    @(negedge clk);
    checks++;
    if (sel4 !== 2'd0 || sp4 !== 1'b0)
      $display("[TB] FAIL fo_pend: got sel=%0d pulse=%b, want 0 0", sel4, sp4);
    else passed++;
    @(negedge clk);
    checks++;
    if (sel4 !== 2'd3 || sp4 !== 1'b1)
      $display("[TB] FAIL fo_to3: got sel=%0d pulse=%b, want 3 1", sel4, sp4);
    else passed++;
    link4 = 4'b1001;
    n_sp = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (sp4 === 1'b1) n_sp++;
    end
    checks++;
    if (sel4 !== 2'd3 || n_sp != 0)
      $display("[TB] FAIL fo_stay3: got sel=%0d pulses=%0d, want 3 0", sel4, n_sp);
    else passed++;
    link4 = 4'b0101;
    repeat (2) @(negedge clk);
    checks++;
    if (sel4 !== 2'd0 || sp4 !== 1'b1)
      $display("[TB] FAIL fo_wrap: got sel=%0d pulse=%b, want 0 1", sel4, sp4);
    else passed++;
    link4 = 4'b0000;
    n_sp = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (sp4 === 1'b1) n_sp++;
    end
    checks++;
    if (sel4 !== 2'd0 || n_sp != 0)
      $display("[TB] FAIL fo_nolink: got sel=%0d pulses=%0d, want 0 0", sel4, n_sp);
    else passed++;
  endtask

  // Links flap every 10 cycles. Switches still happen, but never closer
  // together than the 100-cycle holdoff.
  task automatic test_holdoff();
    int last;
    int min_gap;
    int n_sw;
    last = -1; min_gap = 100000; n_sw = 0;
    for (int c = 0; c < 500; c++) begin
      link4 = (((c / 10) % 2) == 1) ? 4'b0010 : 4'b0001;
      @(negedge clk);
      if (sp4 === 1'b1) begin
        if (last >= 0 && (c - last) < min_gap) min_gap = c - last;
        last = c;
        n_sw++;
      end
    end
    checks++;
    if (n_sw < 2)
      $display("[TB] FAIL hold_switches: got %0d switches, want at least 2", n_sw);
    else passed++;
    checks++;
    if (min_gap < 100)
      $display("[TB] FAIL hold_spacing: got min gap %0d, want >= 100", min_gap);
    else passed++;
  endtask

`ifdef REDUN_SEL_STATS_EN
  // Three automatic failovers give a count of 3; rst clears the count.
  task automatic test_stats();
    auto2 = 1'b1; msel2 = 1'b0; dv2 = '0; link2 = 2'b11;
    @(negedge clk);
    link2 = 2'b10; repeat (3) @(negedge clk);
    link2 = 2'b01; repeat (3) @(negedge clk);
    link2 = 2'b10; repeat (3) @(negedge clk);
    checks++;
    if (fc2 !== 16'd3 || pc2 !== 16'd0 || sel2 !== 1'b1)
      $display("[TB] FAIL stats_count: got failover=%0d poison=%0d sel=%0d, want 3 0 1", fc2, pc2, sel2);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (fc2 !== 16'd0 || pc2 !== 16'd0)
      $display("[TB] FAIL stats_clear: got failover=%0d poison=%0d, want 0 0", fc2, pc2);
    else passed++;
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_forward();
    test_midframe_loss();
    test_manual();
    test_back_to_back();
    test_reset_midframe();
    test_failover();
    test_holdoff();
`ifdef REDUN_SEL_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
